spi_reg_bridge: RTL and testbench

Converts the word stream from the SPI slave deserializer into register-bus reads and writes, and returns register data as the next word to shift back to the master. It sits directly downstream of the SPI slave data serializer/deserializer. It consumes each completed received word plus a one-cycle valid strobe, and drives the serializer's transmit word. Each chip-select frame is one command word followed by any number of data words, with the address auto-incrementing.

---
 rtl/kt_spi_pkg.sv | 22 ++
 rtl/cs_sync.sv | 41 ++++
 rtl/spi_reg_bridge.sv | 136 +++++++++++++
 tb/tb_spi_reg_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kt_spi_pkg.sv
// Shared SPI definitions: default word length, command field helpers
// and the register-bridge FSM state encoding.
package kt_spi_pkg;

  localparam int SPI_WORDLEN_DEF = 8;

  function automatic int cmd_rw_bit(input int wordlen);
    return wordlen - 1;
  endfunction

  function automatic int cmd_addr_w(input int wordlen);
    return wordlen - 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ
  } bridge_state_t;

endpackage

// File: rtl/cs_sync.sv
// Chip-select synchronizer: 2-flop sync, CSPOL decode, edge pulses.
// Ports: clk_in, reset_n, cs_raw in; cs_act, cs_rise, cs_fall out.
module cs_sync #(
  parameter logic CSPOL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic cs_raw,
  output logic cs_act,
  output logic cs_rise,
  output logic cs_fall
);

  logic       s1;
  logic       s2;
  logic       cs_d;
  logic [1:0] settle;
  logic       ready;

  assign cs_act = (s2 == CSPOL);
  // Edges are only trusted once the sync chain and cs_d hold real
  // samples, so a frame already open at reset release is not a rise.
  assign ready   = (settle == 2'd3);
  assign cs_rise = ready & cs_act & ~cs_d;
  assign cs_fall = ready & ~cs_act & cs_d;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= ~CSPOL;
      s2     <= ~CSPOL;
      cs_d   <= 1'b0;
      settle <= 2'd0;
    end else begin
      s1   <= cs_raw;
      s2   <= s1;
      cs_d <= cs_act;
      if (!ready) settle <= settle + 2'd1;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI word stream to register bus bridge with auto-increment bursts.
// Ports: clk_in, reset_n, spi_nCS, rx_word/rx_valid in; tx_word,
// reg_addr/wdata/wr_en/rd_en out, reg_rdata in; frame_active, addr_err.
module spi_reg_bridge
  import kt_spi_pkg::*;
#(
  parameter int   SPI_WORDLEN = SPI_WORDLEN_DEF,
  parameter int   NUM_REGS    = 16,
  parameter logic CSPOL       = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   spi_nCS,
  input  logic [SPI_WORDLEN-1:0] rx_word,
  input  logic                   rx_valid,
  output logic [SPI_WORDLEN-1:0] tx_word,
  output logic [SPI_WORDLEN-2:0] reg_addr,
  output logic [SPI_WORDLEN-1:0] reg_wdata,
  output logic                   reg_wr_en,
  output logic                   reg_rd_en,
  input  logic [SPI_WORDLEN-1:0] reg_rdata,
  output logic                   frame_active,
  output logic                   addr_err
);

  localparam int AW = cmd_addr_w(SPI_WORDLEN);
  localparam int RW = cmd_rw_bit(SPI_WORDLEN);

  bridge_state_t state, state_d;

  logic                   cs_act;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   rd_pend, rd_pend_d;
  logic [AW-1:0]          addr_d;
  logic [AW-1:0]          addr_inc;
  logic [SPI_WORDLEN-1:0] wdata_d;
  logic [SPI_WORDLEN-1:0] tx_d;
  logic                   wr_d;
  logic                   rd_d;
  logic                   err_d;
  logic                   in_range;

  cs_sync #(.CSPOL(CSPOL)) u_cs_sync (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .cs_raw  (spi_nCS),
    .cs_act  (cs_act),
    .cs_rise (cs_rise),
    .cs_fall (cs_fall)
  );

  assign in_range = {1'b0, rx_word[AW-1:0]} < SPI_WORDLEN'(NUM_REGS);
  assign addr_inc = (reg_addr == AW'(NUM_REGS - 1)) ? '0
                  : reg_addr + AW'(1);

  always_comb begin
    state_d   = state;
    addr_d    = reg_addr;
    wdata_d   = reg_wdata;
    tx_d      = tx_word;
    err_d     = addr_err;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    rd_pend_d = reg_rd_en;
    // Read data lands one cycle after the strobe.
    if (rd_pend) tx_d = reg_rdata;
    // Write address advances after its strobe has been seen.
    if (reg_wr_en) addr_d = addr_inc;
    if (cs_fall) begin
      state_d   = S_IDLE;
      tx_d      = '0;
      rd_pend_d = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cs_rise) begin
            state_d = S_CMD;
            err_d   = 1'b0;
            tx_d    = '0;
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            addr_d = rx_word[AW-1:0];
            err_d  = ~in_range;
            if (rx_word[RW]) begin
              state_d = S_READ;
              rd_d    = in_range;
            end else begin
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (rx_valid && !addr_err) begin
            wr_d    = 1'b1;
            wdata_d = rx_word;
          end
        end
        S_READ: begin
          if (rx_valid && !addr_err) begin
            addr_d = addr_inc;
            rd_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_wr_en    <= 1'b0;
      reg_rd_en    <= 1'b0;
      tx_word      <= '0;
      addr_err     <= 1'b0;
      rd_pend      <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      state        <= state_d;
      reg_addr     <= addr_d;
      reg_wdata    <= wdata_d;
      reg_wr_en    <= wr_d;
      reg_rd_en    <= rd_d;
      tx_word      <= tx_d;
      addr_err     <= err_d;
      rd_pend      <= rd_pend_d;
      frame_active <= cs_act;
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge.
// Register file model answers reads one cycle after reg_rd_en.
module tb_spi_reg_bridge;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_nCS = 1'b1;
  logic [7:0] rx_word = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_word;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'hEE;
  logic       frame_active;
  logic       addr_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] regs [16];
  logic [6:0] wr_a [$];
  logic [7:0] wr_v [$];
  logic [6:0] rd_a [$];

  spi_reg_bridge dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .spi_nCS      (spi_nCS),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .tx_word      (tx_word),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_rdata    (reg_rdata),
    .frame_active (frame_active),
    .addr_err     (addr_err)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (reg_rd_en) begin
      reg_rdata <= regs[reg_addr[3:0]];
      rd_a.push_back(reg_addr);
    end else begin
      reg_rdata <= 8'hEE;
    end
    if (reg_wr_en) begin
      wr_a.push_back(reg_addr);
      wr_v.push_back(reg_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic cs_on();
    spi_nCS = 1'b0;
    cyc(6);
  endtask

  task automatic cs_off();
    spi_nCS = 1'b1;
    cyc(6);
  endtask

  task automatic send(input logic [7:0] w);
    rx_word  = w;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(16);
  endtask

  task automatic clear_logs();
    wr_a.delete();
    wr_v.delete();
    rd_a.delete();
  endtask

  task automatic check_wr(input string tag, input int i,
                          input logic [6:0] a, input logic [7:0] v);
    if (wr_a.size() > i) begin
      check({tag, "_addr"}, wr_a[i], a);
      check({tag, "_data"}, wr_v[i], v);
    end else begin
      check({tag, "_missing"}, wr_a.size(), i + 1);
    end
  endtask

  task automatic check_rd(input string tag, input int i,
                          input logic [6:0] a);
    if (rd_a.size() > i) check(tag, rd_a[i], a);
    else check({tag, "_missing"}, rd_a.size(), i + 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'(i * 3 + 1);
    regs[5] = 8'h11;
    regs[6] = 8'h22;
    regs[7] = 8'h33;
    regs[9] = 8'h5A;

    // Reset state
    cyc(3);
    check("rst_tx", tx_word, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wr", reg_wr_en, 0);
    check("rst_rd", reg_rd_en, 0);
    check("rst_fa", frame_active, 0);
    check("rst_err", addr_err, 0);
    reset_n = 1'b1;
    cyc(8);
    check("idle_fa", frame_active, 0);

    // Write burst with frame_active latency
    clear_logs();
    spi_nCS = 1'b0;
    cyc(2);
    check("fa_lat2", frame_active, 0);
    cyc(1);
    check("fa_lat3", frame_active, 1);
    cyc(3);
    send(8'h03);
    send(8'hAA);
    send(8'h55);
    check("wb_cnt", wr_a.size(), 2);
    check_wr("wb0", 0, 7'd3, 8'hAA);
    check_wr("wb1", 1, 7'd4, 8'h55);
    check("wb_rd", rd_a.size(), 0);
    check("wb_err", addr_err, 0);
    cs_off();
    check("wb_fa_off", frame_active, 0);

    // Read burst with prefetch latency
    clear_logs();
    cs_on();
    rx_word  = 8'h85;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    check("rb_rd_en", reg_rd_en, 1);
    check("rb_rd_addr", reg_addr, 5);
    cyc(1);
    check("rb_tx_early", tx_word, 0);
    cyc(1);
    check("rb_tx0", tx_word, 8'h11);
    cyc(14);
    send(8'h00);
    check("rb_tx1", tx_word, 8'h22);
    send(8'h00);
    check("rb_tx2", tx_word, 8'h33);
    check("rb_cnt", rd_a.size(), 3);
    check_rd("rb_a0", 0, 7'd5);
    check_rd("rb_a1", 1, 7'd6);
    check_rd("rb_a2", 2, 7'd7);
    check("rb_wr", wr_a.size(), 0);
    spi_nCS = 1'b1;
    cyc(4);
    check("rb_tx_off", tx_word, 0);
    cyc(4);

    // Address wrap
    clear_logs();
    cs_on();
    send(8'h0F);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    cs_off();
    check("wr_cnt", wr_a.size(), 3);
    check_wr("wrap0", 0, 7'd15, 8'h01);
    check_wr("wrap1", 1, 7'd0, 8'h02);
    check_wr("wrap2", 2, 7'd1, 8'h03);

    // Out-of-range read start
    clear_logs();
    cs_on();
    send(8'h90);
    send(8'h00);
    send(8'h00);
    check("oor_rd", rd_a.size(), 0);
    check("oor_wr", wr_a.size(), 0);
    check("oor_tx", tx_word, 0);
    check("oor_err", addr_err, 1);
    cs_off();
    check("oor_sticky", addr_err, 1);
    cs_on();
    check("oor_clr", addr_err, 0);
    // Out-of-range write start
    send(8'h20);
    send(8'h55);
    check("oorw_wr", wr_a.size(), 0);
    check("oorw_err", addr_err, 1);
    cs_off();
    cs_on();
    check("oorw_clr", addr_err, 0);
    cs_off();

    // Mid-frame abort with word on the synced deassert
    clear_logs();
    cs_on();
    send(8'h02);
    send(8'h77);
    spi_nCS = 1'b1;
    cyc(2);
    rx_word  = 8'h99;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(4);
    check("ab_cnt", wr_a.size(), 1);
    check_wr("ab0", 0, 7'd2, 8'h77);
    check("ab_tx", tx_word, 0);
    check("ab_fa", frame_active, 0);
    send(8'h44);
    check("ab_idle_cnt", wr_a.size(), 1);

    // Reset during a read frame
    clear_logs();
    cs_on();
    send(8'h89);
    check("rr_tx", tx_word, 8'h5A);
    reset_n = 1'b0;
    #1;
    check("rr_tx0", tx_word, 0);
    check("rr_addr0", reg_addr, 0);
    check("rr_rd0", reg_rd_en, 0);
    check("rr_wr0", reg_wr_en, 0);
    check("rr_fa0", frame_active, 0);
    check("rr_err0", addr_err, 0);
    cyc(3);
    reset_n = 1'b1;
    clear_logs();
    cyc(10);
    send(8'h0A);
    send(8'h66);
    check("rr_nowr", wr_a.size(), 0);
    check("rr_nord", rd_a.size(), 0);
    check("rr_fa", frame_active, 1);
    cs_off();
    cs_on();
    send(8'h0A);
    send(8'h66);
    check("rr_cnt", wr_a.size(), 1);
    check_wr("rr_w0", 0, 7'd10, 8'h66);
    cs_off();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
